// File: rtl/fifo.sv
// Single-clock FIFO with wrap-bit pointers; wr_rd picks a write (1) or a read (0) every cycle.
// Define FIFO_STATUS_EN to add the count, overflow and underflow status outputs.
module fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      wr_rd,
    input  logic [DATA_W-1:0]         data_in,
    output logic                      full,
    output logic                      empty,
    output logic [DATA_W-1:0]         data_out
`ifdef FIFO_STATUS_EN
    ,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow,
    output logic                      underflow
`endif
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic              wr_en;
    logic              rd_en;

    // Same low bits with different wrap bits means the writer is a full lap ahead.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

    assign wr_en = wr_rd && !full;
    assign rd_en = !wr_rd && !empty;

    always_ff @(posedge clk) begin
        if (rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            data_out <= '0;
        end else if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_ONE;
        end else if (rd_en) begin
            data_out <= mem[rd_ptr[ADDR_W-1:0]];
            rd_ptr   <= rd_ptr + PTR_ONE;
        end
    end

    // Storage is never cleared; reset only drops it by rewinding the pointers.
    always_ff @(posedge clk) begin
        if (!rstn && wr_en) begin
            mem[wr_ptr[ADDR_W-1:0]] <= data_in;
        end
    end

`ifdef FIFO_STATUS_EN
    assign count = wr_ptr - rd_ptr;

    always_ff @(posedge clk) begin
        if (rstn) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= wr_rd && full;
            underflow <= !wr_rd && empty;
        end
    end
`endif

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: directed vector table, hand-written corner sequences,
// then randomized traffic compared against a queue-based reference model.
module tb_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    logic              clk;
    logic              rstn;
    logic              wr_rd;
    logic [DATA_W-1:0] data_in;
    logic              full;
    logic              empty;
    logic [DATA_W-1:0] data_out;
`ifdef FIFO_STATUS_EN
    logic [4:0]        count;
    logic              overflow;
    logic              underflow;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: plain queue of stored bytes plus the last value read.
    logic [DATA_W-1:0] model_q [$];
    logic [DATA_W-1:0] model_dout = '0;
    logic              model_ovf  = 1'b0;
    logic              model_udf  = 1'b0;

    typedef struct {
        logic              rst;
        logic              wr;
        logic [DATA_W-1:0] din;
        logic              efull;
        logic              eempty;
        logic [DATA_W-1:0] edout;
    } vec_t;

    vec_t vecs [$];

    fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .wr_rd    (wr_rd),
        .data_in  (data_in),
        .full     (full),
        .empty    (empty),
        .data_out (data_out)
`ifdef FIFO_STATUS_EN
        ,
        .count    (count),
        .overflow (overflow),
        .underflow(underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one edge and advances the model by the same rules the FIFO obeys.
    task automatic applyStimulus(input logic rst, input logic wr, input logic [DATA_W-1:0] din);
        @(negedge clk);
        rstn    = rst;
        wr_rd   = wr;
        data_in = din;
        @(posedge clk);
        #1;
        model_ovf = !rst && wr && (model_q.size() == DEPTH);
        model_udf = !rst && !wr && (model_q.size() == 0);
        if (rst) begin
            model_q.delete();
            model_dout = '0;
        end else if (wr) begin
            if (model_q.size() < DEPTH) model_q.push_back(din);
        end else if (model_q.size() > 0) begin
            model_dout = model_q.pop_front();
        end
    endtask

    task automatic checkOutput(input string name, input logic efull, input logic eempty,
                               input logic [DATA_W-1:0] edout);
        checkVal({name, ".full"}, int'(full), int'(efull));
        checkVal({name, ".empty"}, int'(empty), int'(eempty));
        checkVal({name, ".data_out"}, int'(data_out), int'(edout));
`ifdef FIFO_STATUS_EN
        checkVal({name, ".count"}, int'(count), model_q.size());
        checkVal({name, ".overflow"}, int'(overflow), int'(model_ovf));
        checkVal({name, ".underflow"}, int'(underflow), int'(model_udf));
`endif
    endtask

    function automatic void addVec(input logic rst, input logic wr, input logic [DATA_W-1:0] din,
                                   input logic efull, input logic eempty, input logic [DATA_W-1:0] edout);
        vec_t v;
        v.rst = rst; v.wr = wr; v.din = din;
        v.efull = efull; v.eempty = eempty; v.edout = edout;
        vecs.push_back(v);
    endfunction

    initial begin
        logic bias_wr;
        string tag;

        rstn    = 1'b1;
        wr_rd   = 1'b0;
        data_in = '0;

        // Reset for two edges, overfill with 0..31, then overdrain for 32 edges.
        addVec(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00);
        addVec(1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 32; i++)
            addVec(1'b0, 1'b1, 8'(i), i >= 15, 1'b0, 8'h00);
        for (int i = 0; i < 32; i++)
            addVec(1'b0, 1'b0, 8'hEE, 1'b0, i >= 15, (i < 16) ? 8'(i) : 8'h0F);

        foreach (vecs[k]) begin
            applyStimulus(vecs[k].rst, vecs[k].wr, vecs[k].din);
            $sformat(tag, "vec[%0d]", k);
            checkOutput(tag, vecs[k].efull, vecs[k].eempty, vecs[k].edout);
        end

        // Wrap-around: pointers are already past one lap after the overdrain.
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 8'hA0 + 8'(i));
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00);
            checkOutput("wrapA", 1'b0, i == 9, 8'hA0 + 8'(i));
        end
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b1, 8'hB0 + 8'(i));
            checkOutput("wrapB_wr", i == 15, 1'b0, 8'hA9);
        end
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00);
            checkOutput("wrapB_rd", 1'b0, i == 15, 8'hB0 + 8'(i));
        end

        // Reset mid-operation drops stored data and clears data_out.
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 8'h11 + 8'(i));
        applyStimulus(1'b1, 1'b1, 8'h77);
        checkOutput("midreset", 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00);
            checkOutput("postreset_rd", 1'b0, 1'b1, 8'h00);
        end

        // Alternating single write / single read.
        applyStimulus(1'b0, 1'b1, 8'h55);
        checkOutput("alt_wr55", 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("alt_rd55", 1'b0, 1'b1, 8'h55);
        applyStimulus(1'b0, 1'b1, 8'hAA);
        checkOutput("alt_wrAA", 1'b0, 1'b0, 8'h55);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("alt_rdAA", 1'b0, 1'b1, 8'hAA);

        // Random traffic with a direction bias that flips so both flags get exercised.
        bias_wr = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if (i % 40 == 0) bias_wr = ~bias_wr;
            applyStimulus($urandom_range(0, 59) == 0,
                          bias_wr ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
                          8'($urandom));
            checkOutput("random", model_q.size() == DEPTH, model_q.size() == 0, model_dout);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
